// File: rtl/vec_reader.sv
// Read-side sequencer for the dotProduct vector memory: issues one vector's worth of
// reads, hides the 1-cycle read latency in a 2-entry FIFO and streams elements out.
module vec_reader #(
    parameter int DATA_WIDTH  = 8,
    parameter int VETOR_WIDTH = 4,
    parameter int ADDR_WIDTH  = $clog2(VETOR_WIDTH * DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam int CNT_W = $clog2(VETOR_WIDTH) + 1;
    localparam logic [CNT_W-1:0] VEC_LEN  = CNT_W'(VETOR_WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VETOR_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [CNT_W-1:0]      issued_r;
    logic [CNT_W-1:0]      popped_r;
    logic                  inflight_r;
    logic [DATA_WIDTH-1:0] fifo0_r;
    logic [DATA_WIDTH-1:0] fifo1_r;
    logic                  wr_ptr_r;
    logic                  rd_ptr_r;
    logic [1:0]            fifo_count_r;
    logic                  busy_r;
    logic                  done_r;

    logic                  valid_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  issue_s;
    logic                  accept_s;
    logic                  finish_s;
    logic [2:0]            occ_s;
    logic [CNT_W-1:0]      issued_next_s;
    logic [CNT_W-1:0]      popped_next_s;
    logic [DATA_WIDTH-1:0] head_s;

    // Handshake, read-issue throttle and counter look-ahead.
    // occ_s counts FIFO entries plus the read in flight, so every issued read owns a slot.
    always_comb begin
        valid_s       = (fifo_count_r != 2'd0);
        pop_s         = valid_s && m_ready;
        push_s        = inflight_r;
        occ_s         = {1'b0, fifo_count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        issue_s       = (state_r == RUN) && (issued_r < VEC_LEN) && (occ_s < 3'd2);
        issued_next_s = issued_r + CNT_W'(issue_s);
        popped_next_s = popped_r + CNT_W'(pop_s);
        if (rd_ptr_r) begin
            head_s = fifo1_r;
        end else begin
            head_s = fifo0_r;
        end
    end

    // Next-state logic; done is raised on the edge of the final handshake.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = RUN;
                end else begin
                    state_s  = IDLE;
                end
            end
            RUN: begin
                if (issued_next_s == VEC_LEN) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (popped_next_s == VEC_LEN) begin
                    finish_s = 1'b1;
                    state_s  = IDLE;
                end else begin
                    state_s  = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, status and vector bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            base_r     <= '0;
            issued_r   <= '0;
            popped_r   <= '0;
            inflight_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            inflight_r <= issue_s;
            done_r     <= finish_s;
            if (accept_s) begin
                base_r   <= base_addr;
                issued_r <= '0;
                popped_r <= '0;
                busy_r   <= 1'b1;
            end else begin
                issued_r <= issued_next_s;
                popped_r <= popped_next_s;
                if (finish_s) begin
                    busy_r <= 1'b0;
                end
            end
        end
    end

    // Two-entry FIFO capturing read data the cycle after each issued read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo0_r      <= '0;
            fifo1_r      <= '0;
            wr_ptr_r     <= 1'b0;
            rd_ptr_r     <= 1'b0;
            fifo_count_r <= 2'd0;
        end else begin
            if (push_s) begin
                if (wr_ptr_r) begin
                    fifo1_r <= mem_data_out;
                end else begin
                    fifo0_r <= mem_data_out;
                end
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            fifo_count_r <= fifo_count_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign mem_rd_en   = issue_s;
    assign mem_rd_addr = base_r + ADDR_WIDTH'(issued_r);
    assign m_valid     = valid_s;
    assign m_data      = valid_s ? head_s : '0;
    assign m_last      = valid_s && (popped_r == LAST_IDX);

endmodule

// File: tb/tb_vec_reader.sv
// Self-checking bench for vec_reader: registered memory model, queue-based
// scoreboard of expected addresses/elements, directed cases plus random back-pressure.
module tb_vec_reader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] base_addr;
    logic       busy;
    logic       done;
    logic       mem_rd_en;
    logic [4:0] mem_rd_addr;
    logic [7:0] mem_data_out;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_ready;

    vec_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .busy         (busy),
        .done         (done),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_data_out (mem_data_out),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_last       (m_last),
        .m_ready      (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with a one-cycle registered read port.
    logic [7:0] mem [32];
    always @(posedge clk) begin
        if (mem_rd_en) mem_data_out <= mem[mem_rd_addr];
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Scoreboard state
    logic [4:0] exp_addr_q [$];
    logic [7:0] exp_data_q [$];
    int hs_cnt = 0, last_cnt = 0, done_cnt = 0, outst = 0;
    int hs0, last0, done0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       rand_ready = 1'b0;

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        int nxt;
        if (!rst_n) begin
            outst      = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(prev_data));
            end
            if (mem_rd_en) begin
                if (exp_addr_q.size() == 0) chk("extra_read", 32'd1, 32'd0);
                else chk("rd_addr", 32'(mem_rd_addr), 32'(exp_addr_q.pop_front()));
            end
            if (m_valid) begin
                if (exp_data_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
                else chk("m_last", 32'(m_last), 32'(exp_data_q.size() == 1));
            end
            if (m_valid && m_ready) begin
                if (exp_data_q.size() != 0) chk("m_data", 32'(m_data), 32'(exp_data_q.pop_front()));
                hs_cnt++;
                if (m_last) last_cnt++;
            end
            if (done) begin
                done_cnt++;
                chk("busy_at_done", 32'(busy), 32'd0);
            end
            nxt = outst + int'(mem_rd_en) - int'(m_valid && m_ready);
            if (mem_rd_en) chk("outstanding_le2", 32'(nxt <= 2), 32'd1);
            outst      = nxt;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    // Random 50% back-pressure when enabled.
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            m_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic snap();
        hs0   = hs_cnt;
        last0 = last_cnt;
        done0 = done_cnt;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic start_vec(input logic [4:0] b);
        logic [4:0] a;
        for (int i = 0; i < 4; i++) begin
            a = b + 5'(i);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(mem[a]);
        end
        base_addr = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic end_vec(input string tag);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
        chk({tag, "_elems"}, 32'(hs_cnt - hs0), 32'd4);
        chk({tag, "_lasts"}, 32'(last_cnt - last0), 32'd1);
        chk({tag, "_dones"}, 32'(done_cnt - done0), 32'd1);
        chk({tag, "_sb_empty"}, 32'(exp_data_q.size() + exp_addr_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
        chk({tag, "_rd_addr"}, 32'(mem_rd_addr), 32'd0);
        chk({tag, "_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_data"}, 32'(m_data), 32'd0);
        chk({tag, "_last"}, 32'(m_last), 32'd0);
    endtask

    initial begin
        int cyc;
        int c;
        int d;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = 5'd0;
        m_ready   = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = 8'(i * 3 + 1);
        mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;

        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic streaming with m_ready held high
        snap();
        start_vec(5'd4);
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_rd_en_c1", 32'(mem_rd_en), 32'd1);
        chk("basic_valid_c1", 32'(m_valid), 32'd0);
        @(posedge clk); #1;
        chk("basic_valid_c2", 32'(m_valid), 32'd0);
        chk("basic_rd_en_c2", 32'(mem_rd_en), 32'd1);
        @(posedge clk); #1;
        chk("basic_valid_c3", 32'(m_valid), 32'd1);
        chk("basic_first", 32'(m_data), 32'h11);
        wait_done(50, cyc);
        chk("basic_latency", 32'(cyc + 2), 32'd6);
        end_vec("basic");

        // Back-pressure: hold off for 5 cycles after first valid
        m_ready = 1'b0;
        snap();
        start_vec(5'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bp_valid", 32'(m_valid), 32'd1);
        repeat (5) begin
            chk("bp_hold", 32'(m_data), 32'h11);
            chk("bp_rd_stall", 32'(mem_rd_en), 32'd0);
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        wait_done(50, cyc);
        end_vec("bp");

        // Address wrap
        mem[30] = 8'hA5; mem[31] = 8'h5A; mem[0] = 8'h01; mem[1] = 8'h02;
        snap();
        start_vec(5'd30);
        wait_done(50, cyc);
        end_vec("wrap");

        // Start while busy is ignored
        snap();
        start_vec(5'd4);
        base_addr = 5'd0;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(50, cyc);
        end_vec("busy_start");

        // Reset after the second handshake
        snap();
        start_vec(5'd4);
        c = 0;
        while (hs_cnt - hs0 < 2 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        chk("rst_two_elems", 32'(hs_cnt - hs0), 32'd2);
        #1 rst_n = 1'b0;
        #1 check_all_zero("rst_async");
        exp_addr_q.delete();
        exp_data_q.delete();
        d = done_cnt;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_no_done", 32'(done_cnt - d), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        snap();
        start_vec(5'd4);
        wait_done(50, cyc);
        end_vec("post_rst");

        // Random bases, random memory, random back-pressure
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        rand_ready = 1'b1;
        for (int v = 0; v < 20; v++) begin
            snap();
            start_vec(5'($urandom_range(0, 31)));
            wait_done(300, cyc);
            end_vec("rand");
        end
        rand_ready = 1'b0;
        #2 m_ready = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vec_reader.md
Name: vec_reader

Overview:
- Read-side sequencer for the dotProduct vector memory (mem1).
- On a start pulse, issues VETOR_WIDTH consecutive reads starting at a base address.
- Absorbs the memory's 1-cycle registered read latency.
- Streams elements out on a valid/ready interface with a last flag; downstream back-pressure stalls read issue and never loses data.

Parameters:
- DATA_WIDTH, 8, element width; must match the memory.
- VETOR_WIDTH, 4, elements per vector, i.e. reads per start.
- ADDR_WIDTH, clog2(VETOR_WIDTH*DATA_WIDTH) = 5, memory address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  single-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first read address; latched when start is accepted.
- busy  out  1  high from accepted start until the done pulse.
- done  out  1  one-cycle pulse after the last element handshakes.
- mem_rd_en  out  1  read strobe to mem1.
- mem_rd_addr  out  ADDR_WIDTH  read address to mem1.
- mem_data_out  in  DATA_WIDTH  mem1 read data.
  - Valid the cycle after the edge that samples mem_rd_en.
  - Held while rd_en is low.
- m_valid  out  1  output element valid.
- m_data  out  DATA_WIDTH  output element.
- m_last  out  1  marks element VETOR_WIDTH-1; qualified by m_valid.
- m_ready  in  1  downstream accept.

Behaviour:
- Reset (rst_n low, async): all of the following cleared immediately.
  - State returns to IDLE.
  - busy, done, mem_rd_en, m_valid and m_last are 0.
  - mem_rd_addr and m_data are 0.
  - FIFO, inflight flag and counters are cleared.
  - Reset mid-vector abandons the vector; no done pulse.
- State machine: IDLE -> RUN -> DRAIN -> IDLE.
  - IDLE, start=1: latch base_addr, issued=0, popped=0, busy=1, go to RUN.
  - RUN: issue reads until issued==VETOR_WIDTH, then go to DRAIN.
  - DRAIN: wait until popped==VETOR_WIDTH, i.e. FIFO empty and no read inflight.
  - DRAIN exit: done=1 for exactly one cycle, busy=0 in that same cycle, go to IDLE.
  - start while not IDLE is ignored; no queueing.
- Read issue: mem_rd_en = (state==RUN) && (issued<VETOR_WIDTH) && (fifo_count + inflight - pop < 2).
  - pop = m_valid && m_ready.
  - The combinational m_ready -> mem_rd_en path is intended.
- Addressing: mem_rd_addr = base_reg + issued, modulo 2^ADDR_WIDTH.
  - Wrap is legal: base 30 reads 30, 31, 0, 1.
- Latency:
  - inflight is set at the edge that samples mem_rd_en.
  - mem_data_out is pushed into a 2-entry FIFO at the next edge.
  - First m_valid rises 2 edges after the accepting start edge (start at E0, issue at E1, m_valid after E2).
  - With m_ready held high: one element per cycle, and a VETOR_WIDTH vector completes in VETOR_WIDTH+2 cycles from start to done.
- Output:
  - m_data/m_valid/m_last come from the FIFO head and are held stable while m_valid && !m_ready.
  - m_last = m_valid && (popped == VETOR_WIDTH-1).
- FIFO:
  - Never overflows: the issue rule reserves a slot for every inflight read.
  - Simultaneous push and pop with fifo_count==2 is impossible by construction; the bench asserts this.
- Counters: issued and popped are clog2(VETOR_WIDTH)+1 bits wide.

Test Plan:
- Basic: mem[4..7]=11,22,33,44; start base=4, m_ready=1.
  - mem_rd_addr=4,5,6,7 on consecutive cycles.
  - m_data 11,22,33,44 on consecutive cycles, m_last on 44.
  - done 6 cycles after start; busy low with done.
- Back-pressure: same preload; m_ready=0 for 5 cycles after first m_valid, then 1.
  - m_data holds 11 and mem_rd_en stalls after 2 outstanding.
  - No element lost or duplicated; output order 11,22,33,44.
- Wrap: mem[30]=A5, mem[31]=5A, mem[0]=01, mem[1]=02; start base=30.
  - Addresses 30,31,0,1; data A5,5A,01,02.
- Start while busy: second start (base=0) during RUN is ignored.
  - Exactly 4 elements from the first base and one done pulse.
- Reset mid-op: rst_n=0 after 2nd element handshake.
  - All outputs 0 asynchronously (before the next clk edge) and no done pulse.
  - After release, a new start base=4 streams 11..44 correctly.
- Random m_ready (50%) over 20 vectors with random bases vs. a scoreboard model.
  - Zero mismatches.
  - Exactly one m_last and one done per vector.
